// File: rtl/cond_unit.sv
// Condition-check unit: architectural {N,Z,C,V} flag registers, condition evaluation and write gating.
// Optional execute/squash counters are built only when COND_PERF_EN is defined.
module cond_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
`ifdef COND_PERF_EN
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
`else
    output logic [3:0]       Flags
`endif
);

    logic [1:0] nz_q, nz_d;
    logic [1:0] cv_q, cv_d;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_ex;

    assign {flag_n, flag_z} = nz_q;
    assign {flag_c, flag_v} = cv_q;

    // Condition evaluation uses only the registered flags, never this cycle's ALU result.
    always_comb begin : cond_eval
        cond_ex = 1'b1;
        case (Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            default: cond_ex = 1'b1;
        endcase
    end

    // Each flag group updates independently, and only for condition-passed instructions.
    always_comb begin : flag_next
        nz_d = nz_q;
        cv_d = cv_q;
        if (FlagW[1] && cond_ex) begin
            nz_d = ALUFlags[3:2];
        end
        if (FlagW[0] && cond_ex) begin
            cv_d = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin : flag_regs
        if (reset) begin
            nz_q <= 2'b00;
            cv_q <= 2'b00;
        end else begin
            nz_q <= nz_d;
            cv_q <= cv_d;
        end
    end

    assign Flags    = {nz_q, cv_q};
    assign CondEx   = cond_ex;
    assign PCSrc    = PCS & cond_ex;
    assign RegWrite = RegW & cond_ex & ~NoWrite;
    assign MemWrite = MemW & cond_ex;

`ifdef COND_PERF_EN
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] squash_q, squash_d;

    // Exactly one counter advances per edge; both wrap freely.
    always_comb begin : perf_next
        exec_d   = exec_q;
        squash_d = squash_q;
        if (cond_ex) begin
            exec_d = exec_q + CNT_W'(1);
        end else begin
            squash_d = squash_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin : perf_regs
        if (reset) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end

    assign ExecCount   = exec_q;
    assign SquashCount = squash_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: expectations queued at drive time, compared once outputs settle.
module tb_cond_unit;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;
`ifdef COND_PERF_EN
    logic [3:0] ExecCount, SquashCount;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    localparam int SEL_FLAGS  = 0;
    localparam int SEL_CONDEX = 1;
    localparam int SEL_PCSRC  = 2;
    localparam int SEL_REGW   = 3;
    localparam int SEL_MEMW   = 4;
    localparam int SEL_EXEC   = 5;
    localparam int SEL_SQUASH = 6;

    cond_unit #(.CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .Cond        (Cond),
        .ALUFlags    (ALUFlags),
        .FlagW       (FlagW),
        .PCS         (PCS),
        .RegW        (RegW),
        .MemW        (MemW),
        .NoWrite     (NoWrite),
        .PCSrc       (PCSrc),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .CondEx      (CondEx),
`ifdef COND_PERF_EN
        .ExecCount   (ExecCount),
        .SquashCount (SquashCount),
`endif
        .Flags       (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table written from the architectural definitions.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cf;
            4'd3:    return !cf;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cf && !z;
            4'd9:    return !cf || z;
            4'd10:   return n ~^ v;
            4'd11:   return n ^ v;
            4'd12:   return !z && (n ~^ v);
            4'd13:   return z || (n ^ v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_FLAGS:  return 32'(Flags);
            SEL_CONDEX: return 32'(CondEx);
            SEL_PCSRC:  return 32'(PCSrc);
            SEL_REGW:   return 32'(RegWrite);
            SEL_MEMW:   return 32'(MemWrite);
`ifdef COND_PERF_EN
            SEL_EXEC:   return 32'(ExecCount);
            SEL_SQUASH: return 32'(SquashCount);
`endif
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic regw, input logic memw, input logic nw);
        Cond     = c;
        ALUFlags = alu;
        FlagW    = fw;
        PCS      = pcs;
        RegW     = regw;
        MemW     = memw;
        NoWrite  = nw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load an arbitrary flag value through an always-executed full update.
    task automatic load_flags(input logic [3:0] f);
        @(negedge clk);
        drive(4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        push_exp("load_flags", SEL_FLAGS, 32'(f));
        @(negedge clk);
        FlagW = 2'b00;
        drain();
    endtask

    logic [3:0] sweep_flags [7];

    initial begin
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        push_exp("reset_flags", SEL_FLAGS, 32'h0);
        drain();
        @(negedge clk);
        reset = 1'b0;

        // Mid-cycle async reset from all-ones flags
        load_flags(4'b1111);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        push_exp("async_reset_flags", SEL_FLAGS, 32'h0);
        Cond = 4'b0000;
        #1;
        push_exp("reset_eq", SEL_CONDEX, 32'h0);
        drain();
        Cond = 4'b0001;
        #1;
        push_exp("reset_ne", SEL_CONDEX, 32'h1);
        drain();
        @(negedge clk);
        reset = 1'b0;

        // Flag latch then EQ passes with PC write
        @(negedge clk);
        drive(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        push_exp("latch_flags", SEL_FLAGS, 32'h4);
        drain();
        @(negedge clk);
        drive(4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        push_exp("latch_eq_condex", SEL_CONDEX, 32'h1);
        push_exp("latch_eq_pcsrc", SEL_PCSRC, 32'h1);
        drain();

        // Split enables
        @(negedge clk);
        drive(4'b1110, 4'b1011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        push_exp("split_cv", SEL_FLAGS, 32'h7);
        drain();
        @(negedge clk);
        drive(4'b1110, 4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        push_exp("split_nz", SEL_FLAGS, 32'hB);
        drain();

        // Squash: failed EQ with zero flags blocks all writes and flag updates
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        drive(4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        push_exp("squash_condex", SEL_CONDEX, 32'h0);
        push_exp("squash_pcsrc", SEL_PCSRC, 32'h0);
        push_exp("squash_regw", SEL_REGW, 32'h0);
        push_exp("squash_memw", SEL_MEMW, 32'h0);
        drain();
        tick();
        push_exp("squash_flags_hold", SEL_FLAGS, 32'h0);
        drain();

        // Signed compares with N=1, V=0
        load_flags(4'b1000);
        Cond = 4'b1010; #1; push_exp("ge", SEL_CONDEX, 32'h0); drain();
        Cond = 4'b1011; #1; push_exp("lt", SEL_CONDEX, 32'h1); drain();
        Cond = 4'b1100; #1; push_exp("gt", SEL_CONDEX, 32'h0); drain();
        Cond = 4'b1101; #1; push_exp("le", SEL_CONDEX, 32'h1); drain();
        drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        push_exp("nowrite_regw", SEL_REGW, 32'h0);
        push_exp("nowrite_memw", SEL_MEMW, 32'h1);
        drain();
        NoWrite = 1'b0;
        #1;
        push_exp("al_regw", SEL_REGW, 32'h1);
        drain();

        // Full condition table across several flag patterns
        sweep_flags = '{4'b0000, 4'b0100, 4'b0010, 4'b1001, 4'b0110, 4'b1111, 4'b1101};
        foreach (sweep_flags[k]) begin
            load_flags(sweep_flags[k]);
            PCS = 1'b1;
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c);
                #1;
                push_exp($sformatf("tbl_f%b_c%0d", sweep_flags[k], c), SEL_CONDEX,
                         32'(cond_model(4'(c), sweep_flags[k])));
                push_exp($sformatf("tbl_pc_f%b_c%0d", sweep_flags[k], c), SEL_PCSRC,
                         32'(cond_model(4'(c), sweep_flags[k])));
                drain();
            end
            PCS = 1'b0;
        end

`ifdef COND_PERF_EN
        // Counter wrap: 15 pass, 1 fail, 1 pass from a fresh reset
        @(negedge clk);
        reset = 1'b1;
        drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        push_exp("perf_reset_exec", SEL_EXEC, 32'h0);
        push_exp("perf_reset_squash", SEL_SQUASH, 32'h0);
        drain();
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        push_exp("perf_exec_15", SEL_EXEC, 32'hF);
        push_exp("perf_squash_0", SEL_SQUASH, 32'h0);
        drain();
        @(negedge clk);
        Cond = 4'b0000;
        tick();
        @(negedge clk);
        Cond = 4'b1110;
        tick();
        push_exp("perf_exec_wrap", SEL_EXEC, 32'h0);
        push_exp("perf_squash_1", SEL_SQUASH, 32'h1);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
